// File: rtl/covariance_accumulator.sv
// covariance_accumulator: accumulates outer products of multichannel sample
// vectors over a fixed window, then presents a scaled, saturated symmetric
// SIZE_N x SIZE_N matrix and holds it until the consumer acknowledges.
module covariance_accumulator #(
    parameter int unsigned SIZE_N      = 8,
    parameter int unsigned NUM_SAMPLES = 16,
    parameter int unsigned SHIFT       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] sample_in [SIZE_N],
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic signed [31:0] cov_matrix [SIZE_N][SIZE_N],
    output logic               matrix_valid,
    input  logic               matrix_ack,
    output logic        [31:0] sample_count
);

    localparam int unsigned ROW_W = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_SCALE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic [ROW_W-1:0]   row_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               valid_q;
    logic signed [31:0] samp_q [SIZE_N];
    logic signed [63:0] acc_q  [SIZE_N][SIZE_N];
    logic signed [63:0] prod_d [SIZE_N];

    // Clamp a 64-bit signed value into the 32-bit signed range.
    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
        if (v > 64'sh0000_0000_7FFF_FFFF) begin
            sat32 = 32'sh7FFF_FFFF;
        end else if (v < 64'shFFFF_FFFF_8000_0000) begin
            sat32 = 32'sh8000_0000;
        end else begin
            sat32 = 32'(v);
        end
    endfunction

    // Ready only in ACCEPT and never while reset is asserted.
    assign sample_ready = (state_q == ST_ACCEPT) && rst;
    assign matrix_valid = valid_q;
    assign sample_count = count_q;
    assign count_d      = count_q + CNT_W'(1);

    // One row of full-width signed products for the row being accumulated.
    always_comb begin
        for (int j = 0; j < int'(SIZE_N); j++) begin
            prod_d[j] = 64'(samp_q[row_q]) * 64'(samp_q[j]);
        end
    end

    // Control FSM, sample latch, accumulators and result matrix.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_ACCEPT;
            row_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < int'(SIZE_N); i++) begin
                samp_q[i] <= '0;
                for (int j = 0; j < int'(SIZE_N); j++) begin
                    acc_q[i][j]      <= '0;
                    cov_matrix[i][j] <= '0;
                end
            end
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (sample_valid) begin
                        samp_q  <= sample_in;
                        row_q   <= '0;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    for (int j = 0; j < int'(SIZE_N); j++) begin
                        acc_q[row_q][j] <= acc_q[row_q][j] + prod_d[j];
                    end
                    if (row_q == ROW_W'(SIZE_N - 1)) begin
                        count_q <= count_d;
                        state_q <= (count_d == CNT_W'(NUM_SAMPLES)) ? ST_SCALE : ST_ACCEPT;
                    end else begin
                        row_q <= row_q + ROW_W'(1);
                    end
                end
                ST_SCALE: begin
                    for (int i = 0; i < int'(SIZE_N); i++) begin
                        for (int j = 0; j < int'(SIZE_N); j++) begin
                            cov_matrix[i][j] <= sat32(acc_q[i][j] >>> SHIFT);
                        end
                    end
                    valid_q <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (matrix_ack) begin
                        for (int i = 0; i < int'(SIZE_N); i++) begin
                            for (int j = 0; j < int'(SIZE_N); j++) begin
                                acc_q[i][j] <= '0;
                            end
                        end
                        count_q <= '0;
                        valid_q <= 1'b0;
                        state_q <= ST_ACCEPT;
                    end
                end
                default: state_q <= ST_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_covariance_accumulator.sv
// Directed bench for covariance_accumulator with SIZE_N=4, NUM_SAMPLES=4, SHIFT=2.
module tb_covariance_accumulator;

    logic               clk;
    logic               rst;
    logic signed [31:0] sample_in [4];
    logic               sample_valid;
    logic               sample_ready;
    logic signed [31:0] cov_matrix [4][4];
    logic               matrix_valid;
    logic               matrix_ack;
    logic        [31:0] sample_count;

    int n_cmp;
    int n_err;
    logic signed [31:0] exp_m [4][4];
    logic signed [31:0] snap  [4][4];

    covariance_accumulator #(.SIZE_N(4), .NUM_SAMPLES(4), .SHIFT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .cov_matrix   (cov_matrix),
        .matrix_valid (matrix_valid),
        .matrix_ack   (matrix_ack),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected matrix for four identical samples s: sat32((4*s_i*s_j) >>> 2).
    task automatic fill_exp(input longint s0, input longint s1, input longint s2, input longint s3);
        longint s [4];
        longint v;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                v = (4 * s[i] * s[j]) >>> 2;
                if (v > 64'sd2147483647) v = 64'sd2147483647;
                if (v < -64'sd2147483648) v = -64'sd2147483648;
                exp_m[i][j] = 32'(v);
            end
        end
    endtask

    // Present one sample and hold valid until the handshake edge; returns 1 time unit after it.
    task automatic send_sample(input int v0, input int v1, input int v2, input int v3);
        int guard;
        @(negedge clk);
        sample_in[0] = v0; sample_in[1] = v1; sample_in[2] = v2; sample_in[3] = v3;
        sample_valid = 1'b1;
        guard = 0;
        while (!sample_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            n_cmp++; n_err++;
            $display("FAIL send_sample timeout: sample_ready stayed 0 for %0d cycles", guard);
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        for (int k = 0; k < 4; k++) sample_in[k] = 32'sh0BAD_F00D;
    endtask

    task automatic wait_valid(input string tag);
        int guard;
        guard = 0;
        while (!matrix_valid && guard < 64) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 64) begin
            n_cmp++; n_err++;
            $display("FAIL %s wait_valid timeout: matrix_valid=%0b after %0d cycles", tag, matrix_valid, guard);
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        matrix_ack = 1'b1;
        @(posedge clk);
        #1;
        matrix_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; sample_valid = 1'b0; matrix_ack = 1'b0;
        for (int k = 0; k < 4; k++) sample_in[k] = '0;
        #1;
        n_cmp++;
        if (sample_ready !== 1'b0) begin n_err++; $display("FAIL reset ready_pre got %0b want 0", sample_ready); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (sample_ready !== 1'b0) begin n_err++; $display("FAIL reset ready got %0b want 0", sample_ready); end
        n_cmp++;
        if (matrix_valid !== 1'b0) begin n_err++; $display("FAIL reset matrix_valid got %0b want 0", matrix_valid); end
        n_cmp++;
        if (sample_count !== 32'd0) begin n_err++; $display("FAIL reset sample_count got %0d want 0", sample_count); end
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (cov_matrix[i][j] !== 32'sd0) begin n_err++; $display("FAIL reset cov[%0d][%0d] got %0d want 0", i, j, cov_matrix[i][j]); end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (sample_ready !== 1'b1) begin n_err++; $display("FAIL reset ready_after got %0b want 1", sample_ready); end
    endtask

    task automatic test_basic();
        fill_exp(1, 2, 3, 4);
        repeat (3) send_sample(1, 2, 3, 4);
        send_sample(1, 2, 3, 4);
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (sample_count !== 32'd3) begin n_err++; $display("FAIL basic count_mid got %0d want 3", sample_count); end
        @(posedge clk); #1;
        n_cmp++;
        if (matrix_valid !== 1'b0) begin n_err++; $display("FAIL basic valid_early got %0b want 0", matrix_valid); end
        @(posedge clk); #1;
        n_cmp++;
        if (matrix_valid !== 1'b1) begin n_err++; $display("FAIL basic valid_latency got %0b want 1", matrix_valid); end
        n_cmp++;
        if (sample_count !== 32'd4) begin n_err++; $display("FAIL basic sample_count got %0d want 4", sample_count); end
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (cov_matrix[i][j] !== exp_m[i][j]) begin n_err++; $display("FAIL basic cov[%0d][%0d] got %0d want %0d", i, j, cov_matrix[i][j], exp_m[i][j]); end
        end
        pulse_ack();
    endtask

    task automatic test_negative();
        fill_exp(-1, 1, -1, 1);
        repeat (4) send_sample(-1, 1, -1, 1);
        wait_valid("negative");
        n_cmp++;
        if (cov_matrix[0][1] !== -32'sd1) begin n_err++; $display("FAIL negative cov01 got %0d want -1", cov_matrix[0][1]); end
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (cov_matrix[i][j] !== exp_m[i][j]) begin n_err++; $display("FAIL negative cov[%0d][%0d] got %0d want %0d", i, j, cov_matrix[i][j], exp_m[i][j]); end
        end
        pulse_ack();
    endtask

    task automatic test_saturation();
        fill_exp(65536, -65536, 0, 0);
        repeat (4) send_sample(65536, -65536, 0, 0);
        wait_valid("saturation");
        n_cmp++;
        if (cov_matrix[0][0] !== 32'sh7FFF_FFFF) begin n_err++; $display("FAIL sat cov00 got %0d want 2147483647", cov_matrix[0][0]); end
        n_cmp++;
        if (cov_matrix[0][1] !== 32'sh8000_0000) begin n_err++; $display("FAIL sat cov01 got %0d want -2147483648", cov_matrix[0][1]); end
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (cov_matrix[i][j] !== exp_m[i][j]) begin n_err++; $display("FAIL sat cov[%0d][%0d] got %0d want %0d", i, j, cov_matrix[i][j], exp_m[i][j]); end
        end
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        logic [29:0] obs;
        logic [29:0] exp_r;
        int accepted;
        logic same;
        fill_exp(3, -2, 0, 1);
        exp_r = '0;
        exp_r[0] = 1'b1; exp_r[5] = 1'b1; exp_r[10] = 1'b1; exp_r[15] = 1'b1;
        accepted = 0;
        @(negedge clk);
        sample_in[0] = 3; sample_in[1] = -2; sample_in[2] = 0; sample_in[3] = 1;
        sample_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            obs[k] = sample_ready;
            if (sample_ready && sample_valid) accepted++;
        end
        n_cmp++;
        if (obs !== exp_r) begin n_err++; $display("FAIL stream ready_pattern got %b want %b", obs, exp_r); end
        n_cmp++;
        if (accepted != 4) begin n_err++; $display("FAIL stream accepted got %0d want 4", accepted); end
        n_cmp++;
        if (sample_count !== 32'd4) begin n_err++; $display("FAIL stream sample_count got %0d want 4", sample_count); end
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (cov_matrix[i][j] !== exp_m[i][j]) begin n_err++; $display("FAIL stream cov[%0d][%0d] got %0d want %0d", i, j, cov_matrix[i][j], exp_m[i][j]); end
        end
        snap = cov_matrix;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            same = 1'b1;
            for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++)
                if (cov_matrix[i][j] !== snap[i][j]) same = 1'b0;
            n_cmp++;
            if (matrix_valid !== 1'b1) begin n_err++; $display("FAIL hold matrix_valid cycle %0d got %0b want 1", c, matrix_valid); end
            n_cmp++;
            if (sample_ready !== 1'b0) begin n_err++; $display("FAIL hold sample_ready cycle %0d got %0b want 0", c, sample_ready); end
            n_cmp++;
            if (same !== 1'b1) begin n_err++; $display("FAIL hold cov_stable cycle %0d got %0b want 1", c, same); end
        end
        matrix_ack = 1'b1;
        @(posedge clk);
        #1;
        matrix_ack = 1'b0;
        n_cmp++;
        if (matrix_valid !== 1'b0) begin n_err++; $display("FAIL ack matrix_valid got %0b want 0", matrix_valid); end
        n_cmp++;
        if (sample_ready !== 1'b1) begin n_err++; $display("FAIL ack sample_ready got %0b want 1", sample_ready); end
        n_cmp++;
        if (sample_count !== 32'd0) begin n_err++; $display("FAIL ack sample_count got %0d want 0", sample_count); end
        sample_valid = 1'b0;
        n_cmp++;
        if (cov_matrix[0][0] !== exp_m[0][0]) begin n_err++; $display("FAIL ack cov_kept got %0d want %0d", cov_matrix[0][0], exp_m[0][0]); end
    endtask

    task automatic test_reset_mid();
        send_sample(5, 5, 5, 5);
        send_sample(5, 5, 5, 5);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (sample_ready !== 1'b0) begin n_err++; $display("FAIL rstmid sample_ready got %0b want 0", sample_ready); end
        rst = 1'b1;
        n_cmp++;
        if (sample_count !== 32'd0) begin n_err++; $display("FAIL rstmid sample_count got %0d want 0", sample_count); end
        n_cmp++;
        if (matrix_valid !== 1'b0) begin n_err++; $display("FAIL rstmid matrix_valid got %0b want 0", matrix_valid); end
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (cov_matrix[i][j] !== 32'sd0) begin n_err++; $display("FAIL rstmid cov[%0d][%0d] got %0d want 0", i, j, cov_matrix[i][j]); end
        end
        repeat (4) send_sample(1, 1, 1, 1);
        wait_valid("rstmid");
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (cov_matrix[i][j] !== 32'sd1) begin n_err++; $display("FAIL rstmid_after cov[%0d][%0d] got %0d want 1", i, j, cov_matrix[i][j]); end
        end
        pulse_ack();
    endtask

    task automatic test_ack_ignored();
        fill_exp(2, -3, 1, 0);
        pulse_ack();
        n_cmp++;
        if (sample_ready !== 1'b1) begin n_err++; $display("FAIL ackign accept_ready got %0b want 1", sample_ready); end
        send_sample(2, -3, 1, 0);
        matrix_ack = 1'b1;
        @(posedge clk);
        #1;
        matrix_ack = 1'b0;
        repeat (3) send_sample(2, -3, 1, 0);
        wait_valid("ackign");
        n_cmp++;
        if (sample_count !== 32'd4) begin n_err++; $display("FAIL ackign sample_count got %0d want 4", sample_count); end
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (cov_matrix[i][j] !== exp_m[i][j]) begin n_err++; $display("FAIL ackign cov[%0d][%0d] got %0d want %0d", i, j, cov_matrix[i][j], exp_m[i][j]); end
        end
        pulse_ack();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_ack_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
